// File: rtl/alu_pipe_ctrl.sv
// rtl/alu_pipe_ctrl.sv - two-stage handshaked ALU front end with completion/illegal counters
module alu_pipe_ctrl #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_o,
    output logic             res_zero,
    output logic             res_illegal,
    output logic [CNT_W-1:0] done_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    logic             r_s1_v;
    logic [31:0]      r_s1_a;
    logic [7:0]       r_s1_b;
    logic [2:0]       r_s1_s;
    logic             r_res_valid;
    logic [31:0]      r_res_o;
    logic             r_res_zero;
    logic             r_res_illegal;
    logic [CNT_W-1:0] r_done_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_s2_en;
    logic             w_accept;
    logic             w_res_hs;
    logic [31:0]      w_bz;
    logic [31:0]      w_result;
    logic             w_illegal;

    // Output stage may load whenever it is empty or being drained this cycle.
    assign w_s2_en   = !r_res_valid || res_ready;
    // While reset is held the pipeline is empty, so requests are shown as acceptable.
    assign cmd_ready = rst || (!flush && (!r_s1_v || w_s2_en));
    assign w_accept  = cmd_valid && cmd_ready && !rst;
    // A flush in the same cycle cancels the delivery, so it is not counted.
    assign w_res_hs  = r_res_valid && res_ready && !flush;
    assign w_bz      = {24'h0, r_s1_b};

    // ALU function on the stage-1 contents; undefined opcodes yield 0 and are flagged.
    always_comb begin
        w_result  = 32'h0;
        w_illegal = 1'b0;
        case (r_s1_s)
            3'b000:  w_result = r_s1_a + w_bz;
            3'b001:  w_result = w_bz - r_s1_a;
            3'b010:  w_result = r_s1_a & w_bz;
            3'b011:  w_result = r_s1_a | w_bz;
            3'b100:  w_result = ~w_bz;
            default: begin
                w_result  = 32'h0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Stage 1: capture accepted requests, empty when the entry moves on with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1_a <= 32'h0;
            r_s1_b <= 8'h0;
            r_s1_s <= 3'b000;
        end else if (flush) begin
            r_s1_v <= 1'b0;
        end else if (w_accept) begin
            r_s1_v <= 1'b1;
            r_s1_a <= cmd_a;
            r_s1_b <= cmd_b;
            r_s1_s <= cmd_s;
        end else if (w_s2_en) begin
            r_s1_v <= 1'b0;
        end
    end

    // Stage 2: registered result, frozen while the consumer stalls a valid result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_o       <= 32'h0;
            r_res_zero    <= 1'b0;
            r_res_illegal <= 1'b0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
        end else if (w_s2_en) begin
            r_res_valid <= r_s1_v;
            if (r_s1_v) begin
                r_res_o       <= w_result;
                r_res_zero    <= (w_result == 32'h0);
                r_res_illegal <= w_illegal;
            end
        end
    end

    // Delivered-result counters: completions wrap, illegal deliveries saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_res_hs) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
            if (r_res_illegal && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_o       = r_res_o;
    assign res_zero    = r_res_zero;
    assign res_illegal = r_res_illegal;
    assign done_cnt    = r_done_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// tb/tb_alu_pipe_ctrl.sv - directed and random checks of alu_pipe_ctrl against a queue model
module tb_alu_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, cmd_valid, res_ready;
    logic [31:0] cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_s;
    logic        cmd_ready, res_valid, res_zero, res_illegal;
    logic [31:0] res_o;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;
    logic        cmd_ready4, res_valid4, res_zero4, res_illegal4;
    logic [31:0] res_o4;
    logic [3:0]  done_cnt4;
    logic [7:0]  err_cnt4;

    always #5 clk = ~clk;

    alu_pipe_ctrl #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .res_valid(res_valid), .res_ready(res_ready),
        .res_o(res_o), .res_zero(res_zero), .res_illegal(res_illegal),
        .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    alu_pipe_ctrl #(.CNT_W(4), .ERR_W(8)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .res_valid(res_valid4), .res_ready(res_ready),
        .res_o(res_o4), .res_zero(res_zero4), .res_illegal(res_illegal4),
        .done_cnt(done_cnt4), .err_cnt(err_cnt4)
    );

    typedef struct {
        logic [31:0] r;
        logic        il;
        int          e;
    } ent_t;

    ent_t        q[$];
    logic [31:0] got[$];
    int          edge_n = 0;
    int          exp_done = 0;
    int          exp_err = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic ent_t alu_ref(input logic [31:0] a, input logic [7:0] b, input logic [2:0] s);
        ent_t        t;
        logic [31:0] bz;
        bz   = {24'h0, b};
        t.il = 1'b0;
        t.e  = 0;
        case (s)
            3'd0:    t.r = a + bz;
            3'd1:    t.r = bz - a;
            3'd2:    t.r = a & bz;
            3'd3:    t.r = a | bz;
            3'd4:    t.r = ~bz;
            default: begin t.r = 32'h0; t.il = 1'b1; end
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        exp_done = 0;
        exp_err  = 0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model across the edge.
    task automatic cyc();
        logic exp_valid, exp_ready, acc, hs;
        ent_t n;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (edge_n >= q[0].e + 1);
        exp_ready = !flush && !(q.size() == 2 && !res_ready);
        check("cmd_ready", cmd_ready, exp_ready);
        check("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
            check("res_o", res_o, q[0].r);
            check("res_zero", res_zero, q[0].r == 32'h0);
            check("res_illegal", res_illegal, q[0].il);
        end
        check("done_cnt", done_cnt, exp_done % 65536);
        check("done_cnt4", done_cnt4, exp_done % 16);
        check("err_cnt", err_cnt, exp_err);
        acc = cmd_valid && exp_ready;
        hs  = exp_valid && res_ready && !flush;
        n   = alu_ref(cmd_a, cmd_b, cmd_s);
        @(posedge clk);
        edge_n++;
        if (flush) begin
            q.delete();
        end else begin
            if (hs) begin
                got.push_back(q[0].r);
                if (q[0].il && exp_err < 255) exp_err++;
                exp_done++;
                void'(q.pop_front());
            end
            if (acc) begin
                n.e = edge_n;
                q.push_back(n);
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] b, input logic [2:0] s);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_s     = s;
    endtask

    logic [31:0] plan1[6];
    int          base;

    initial begin
        plan1 = '{32'h00000006, 32'h0, 32'hFFFFFFFF, 32'hFFFFFF00, 32'h00000030, 32'hF0F0F0FC};
        rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_o", res_o, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back legal ops with the consumer always ready.
        drive(1'b1, 32'h1, 8'h05, 3'd0);        cyc();
        drive(1'b1, 32'h5, 8'h05, 3'd1);        cyc();
        drive(1'b1, 32'h1, 8'h00, 3'd1);        cyc();
        drive(1'b1, 32'h0, 8'hFF, 3'd4);        cyc();
        drive(1'b1, 32'hF0F0F0F0, 8'h3C, 3'd2); cyc();
        drive(1'b1, 32'hF0F0F0F0, 8'h3C, 3'd3); cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (3) cyc();
        for (int i = 0; i < 6; i++) check($sformatf("plan1_%0d", i), got[i], plan1[i]);
        check("plan1_done", done_cnt, 6);

        // Backpressure: two buffered, third waits until the consumer drains.
        res_ready = 1'b0;
        drive(1'b1, 32'h10, 8'h01, 3'd0); cyc();
        drive(1'b1, 32'h20, 8'h02, 3'd0); cyc();
        drive(1'b1, 32'h30, 8'h03, 3'd0);
        repeat (4) cyc();
        check("bp_q_depth", q.size(), 2);
        res_ready = 1'b1;
        cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (4) cyc();
        check("bp_drain0", got[6], 32'h11);
        check("bp_drain1", got[7], 32'h22);
        check("bp_drain2", got[8], 32'h33);

        // Illegal opcode repeated until the error counter saturates.
        base = exp_done;
        drive(1'b1, 32'h7, 8'h07, 3'd7);
        repeat (300) cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (3) cyc();
        check("ill_err_sat", err_cnt, 8'hFF);
        check("ill_done", done_cnt, base + 300);

        // Flush with both stages occupied and the consumer stalled.
        res_ready = 1'b0;
        drive(1'b1, 32'h100, 8'h01, 3'd0); cyc();
        drive(1'b1, 32'h200, 8'h02, 3'd0); cyc();
        base = exp_done;
        flush = 1'b1; cyc();
        flush = 1'b0; drive(1'b0, 32'h0, 8'h0, 3'd0); cyc();
        check("flush_done_same", done_cnt, base);
        res_ready = 1'b1;
        drive(1'b1, 32'h5, 8'h06, 3'd3); cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (3) cyc();
        check("flush_next_op", got[got.size()-1], 32'h7);

        // Asynchronous reset mid-cycle with two ops in flight.
        res_ready = 1'b0;
        drive(1'b1, 32'h1, 8'h01, 3'd0); cyc();
        drive(1'b1, 32'h2, 8'h02, 3'd0); cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_res_valid", res_valid, 0);
        check("arst_res_o", res_o, 0);
        check("arst_done", done_cnt, 0);
        check("arst_err", err_cnt, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        clear_model();
        @(posedge clk);
        edge_n++;
        #2 rst = 1'b0;
        res_ready = 1'b1;
        drive(1'b1, 32'h40, 8'h04, 3'd0); cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);   cyc();
        check("arst_lat", res_valid, 1);
        check("arst_first", res_o, 32'h44);
        cyc();

        // Sixteen more completions: seventeen since reset wraps the 4-bit counter to 1.
        drive(1'b1, 32'h9, 8'h09, 3'd2);
        repeat (16) cyc();
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (3) cyc();
        check("wrap_done4", done_cnt4, 4'd1);
        check("wrap_done16", done_cnt, 17);

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom), 3'($urandom_range(0, 7)));
            res_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            cyc();
        end
        flush = 1'b0; res_ready = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 3'd0);
        repeat (4) cyc();
        check("rand_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe_ctrl.md
Name: alu_pipe_ctrl

Overview:
Pipelined, handshaked front end for the team's 5-op ALU datapath, with the ALU function computed internally.
- Accepts operation requests (a, b, s) over valid/ready.
- Computes the ALU function in a registered 2-stage pipeline.
- Returns result, zero and illegal flags over valid/ready with full backpressure.
- Sits between the instruction sequencer and the register-file writeback. It is the requesting/consuming side that the combinational ALU lacks.

Parameters:
CNT_W, 16, width of completed-operation counter done_cnt
ERR_W, 8, width of saturating illegal-op counter err_cnt

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous pipeline clear
cmd_valid  in  1  request valid
cmd_ready  out  1  request accepted when cmd_valid && cmd_ready at clk edge
cmd_a  in  32  operand a
cmd_b  in  8  operand b, zero-extended to 32 internally (bz = {24'h0, cmd_b})
cmd_s  in  3  opcode
res_valid  out  1  result valid
res_ready  in  1  consumer ready
res_o  out  32  result
res_zero  out  1  res_o == 0
res_illegal  out  1  opcode was not 000..100
done_cnt  out  CNT_W  result handshakes completed, wraps
err_cnt  out  ERR_W  illegal results delivered, saturates at all-ones

Behaviour:
Reset:
- rst high clears s1_v, res_valid, res_o, res_zero, res_illegal, done_cnt and err_cnt to 0 immediately, independent of clk.
- cmd_ready reads 1 while rst is high.
- A request or result in flight is discarded.

Opcode function (bz = {24'h0, b}):
- 000: a + bz, mod 2^32
- 001: bz - a, mod 2^32
- 010: a & bz
- 011: a | bz
- 100: ~bz
- 101, 110, 111: result 0, res_illegal = 1
- res_zero is computed from the final 32-bit result, including for illegal ops.

Stage 1 (input register s1: s1_v, a, b, s):
- s2_en = !res_valid || res_ready.
- cmd_ready = !flush && (!s1_v || s2_en). This is combinational; no dependency on cmd_valid.
- On accept, load s1 and set s1_v = 1.
- If s1 advances with no new accept, clear s1_v.

Stage 2 (output register):
- When s2_en: res_valid <= s1_v. If s1_v, load res_o, res_zero and res_illegal from the s1 contents.
- When !s2_en: all res_* outputs hold stable. A res_* change while res_valid && !res_ready is a bug.

Latency and throughput:
- Accept at edge k gives res_valid = 1 after edge k+1 (2-edge latency).
- Throughput is 1 op/cycle while res_ready stays high.
- With res_ready low, at most 2 ops are buffered (s1 plus output); cmd_ready then drops.

Flush:
- At the clock edge, clears s1_v and res_valid.
- No accept that cycle.
- Counters are unchanged; data registers may hold stale values.
- Flush has priority over the result handshake in the same cycle: the transfer is not counted.

Counters:
- done_cnt increments on res_valid && res_ready && !flush and wraps from 2^CNT_W-1 to 0.
- err_cnt increments on the same condition when res_illegal = 1, and holds at 2^ERR_W-1.

Simultaneous events:
- Accept and result handshake in the same cycle are both honoured, with no bubble.
- cmd_valid may deassert without an accept; no request is latched.

Test Plan:
1. Back-to-back ops with res_ready=1:
   - a=1, b=05, s=000 -> o=00000006, zero=0
   - a=5, b=05, s=001 -> o=0, zero=1
   - a=1, b=00, s=001 -> o=FFFFFFFF
   - b=FF, s=100 -> o=FFFFFF00
   - a=F0F0F0F0, b=3C, s=010 -> o=00000030
   - a=F0F0F0F0, b=3C, s=011 -> o=F0F0F0FC
   Check: results in order, one per cycle, first res_valid at edge 2 after the first accept, done_cnt=6.
2. Backpressure: hold res_ready=0 and issue 3 commands.
   - Only 2 are accepted; cmd_ready=0 on the third.
   - res_o stays stable.
   - Releasing res_ready drains both results in order with no loss or duplication, then the third is accepted.
3. Illegal ops: issue s=111 (a=7, b=7) 300 times -> each gives o=0, zero=1, illegal=1; err_cnt saturates at FF; done_cnt=300.
4. Flush with 2 ops in flight and res_ready=0 -> next cycle res_valid=0 and cmd_ready=1; counters unchanged; the next op completes normally.
5. Assert rst asynchronously between edges with 2 ops in flight -> outputs and counters read 0 immediately; after release, the first op gives the correct result with 2-edge latency.
6. Wrap: with CNT_W=4, complete 17 handshakes -> done_cnt=1.
